// File: rtl/instruction_memory_loader.sv
// Boot-time program loader for the instruction memory.
//
// Receives a framed byte stream (SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, 4*N data bytes,
// CSUM) and writes each data byte into the instruction memory through its Avalon write
// port, one byte lane at a time. The CPU is held in reset while a frame is in flight.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   s_valid, s_data, s_ready     input byte stream (transfer on s_valid & s_ready)
//   mem_address, mem_byteenable  word address and one-hot lane of the current write
//   mem_chipselect, mem_write    single-cycle write strobes
//   mem_writedata                data byte replicated across all four lanes
//   cpu_reset_req                holds the processor in reset while loading
//   busy                         frame in progress
//   done, error, err_code        sticky result of the most recent frame
module instruction_memory_loader #(
    parameter int unsigned DEPTH          = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic [15:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic        cpu_reset_req,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle, StAddrH, StAddrL, StCntH, StCntL, StData, StCsum, StFin
    } state_e;

    state_e state_q, state_d;

    logic            ready_q;
    logic [15:0]     addr_q;        // start address, then running word pointer
    logic [7:0]      cnt_hi_q;
    logic [15:0]     words_left_q;
    logic [1:0]      lane_q;
    logic [7:0]      sum_q;
    logic [TmoW-1:0] tmo_q;
    logic            we_q;
    logic [15:0]     mem_addr_q;
    logic [3:0]      mem_be_q;
    logic [31:0]     mem_wdata_q;
    logic            cpu_rst_q;
    logic            done_q;
    logic            error_q;
    logic [1:0]      err_code_q;

    logic        fire;
    logic        active;
    logic        tmo_hit;
    logic        range_bad;
    logic        last_byte;
    logic [16:0] end_word;
    logic [15:0] cnt_full;
    logic [7:0]  csum_total;

    assign fire       = s_valid & ready_q;
    assign active     = (state_q != StIdle) && (state_q != StFin);
    assign cnt_full   = {cnt_hi_q, s_data};
    assign end_word   = {1'b0, addr_q} + {1'b0, cnt_full};
    assign range_bad  = end_word > 17'(DEPTH);
    assign last_byte  = (lane_q == 2'd3) && (words_left_q == 16'd1);
    assign csum_total = sum_q + s_data;
    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
    assign tmo_hit    = active && !fire && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (fire && s_data == SYNC_BYTE) state_d = StAddrH;
            StAddrH: if (fire) state_d = StAddrL;
            StAddrL: if (fire) state_d = StCntH;
            StCntH:  if (fire) state_d = StCntL;
            StCntL: begin
                if (fire) begin
                    if (range_bad)              state_d = StFin;
                    else if (cnt_full == 16'd0) state_d = StCsum;
                    else                        state_d = StData;
                end
            end
            StData:  if (fire && last_byte) state_d = StCsum;
            StCsum:  if (fire) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (tmo_hit) state_d = StFin;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            ready_q      <= 1'b0;
            addr_q       <= '0;
            cnt_hi_q     <= '0;
            words_left_q <= '0;
            lane_q       <= '0;
            sum_q        <= '0;
            tmo_q        <= '0;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            cpu_rst_q    <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != StFin);
            we_q    <= 1'b0;
            tmo_q   <= (active && !fire) ? tmo_q + TmoW'(1) : '0;

            if (fire) begin
                unique case (state_q)
                    StIdle: begin
                        if (s_data == SYNC_BYTE) begin
                            done_q     <= 1'b0;
                            error_q    <= 1'b0;
                            err_code_q <= 2'd0;
                            cpu_rst_q  <= 1'b1;
                            sum_q      <= '0;
                        end
                    end
                    StAddrH: addr_q[15:8] <= s_data;
                    StAddrL: addr_q[7:0]  <= s_data;
                    StCntH:  cnt_hi_q     <= s_data;
                    StCntL: begin
                        words_left_q <= cnt_full;
                        lane_q       <= 2'd0;
                        if (range_bad) begin
                            error_q    <= 1'b1;
                            err_code_q <= 2'd1;
                        end
                    end
                    StData: begin
                        we_q        <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_be_q    <= 4'b0001 << lane_q;
                        mem_wdata_q <= {4{s_data}};
                        sum_q       <= sum_q + s_data;
                        lane_q      <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            addr_q       <= addr_q + 16'd1;
                            words_left_q <= words_left_q - 16'd1;
                        end
                    end
                    StCsum: begin
                        if (csum_total == 8'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            error_q    <= 1'b1;
                            err_code_q <= 2'd2;
                        end
                    end
                    default: ;
                endcase
            end

            if (tmo_hit) begin
                error_q    <= 1'b1;
                err_code_q <= 2'd3;
            end

            // CPU reset is released on the edge that leaves FIN.
            if (state_q == StFin) cpu_rst_q <= 1'b0;
        end
    end

    assign s_ready        = ready_q;
    assign mem_address    = mem_addr_q;
    assign mem_byteenable = mem_be_q;
    assign mem_chipselect = we_q;
    assign mem_write      = we_q;
    assign mem_writedata  = mem_wdata_q;
    assign cpu_reset_req  = cpu_rst_q;
    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign error          = error_q;
    assign err_code       = err_code_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed testbench for instruction_memory_loader (TIMEOUT_CYCLES = 16).
module tb_instruction_memory_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        reset_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        cpu_reset_req;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int n_pass = 0;
    int n_total = 0;

    logic [15:0] log_addr[$];
    logic [3:0]  log_be[$];
    logic [31:0] log_data[$];

    instruction_memory_loader #(
        .DEPTH          (50000),
        .TIMEOUT_CYCLES (16),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .cpu_reset_req  (cpu_reset_req),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .err_code       (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write pulses are one cycle wide, so sampling on the falling edge logs each once.
    always @(negedge clk) begin
        if (mem_write && mem_chipselect) begin
            log_addr.push_back(mem_address);
            log_be.push_back(mem_byteenable);
            log_data.push_back(mem_writedata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_be.delete();
        log_data.delete();
    endtask

    // Leaves s_valid high; returns 1ns after the transferring edge.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_wait", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input byte_q_t bytes, input int gap_max);
        for (int i = 0; i < bytes.size(); i++) begin
            if (gap_max > 0 && i > 0) begin
                int g;
                g = $urandom_range(gap_max, 0);
                s_valid = 1'b0;
                repeat (g) @(posedge clk);
                #1;
            end
            send_byte(bytes[i]);
        end
        s_valid = 1'b0;
    endtask

    // Expects the eight writes of the 11..88 test program starting at word base.
    task automatic check_writes(input string tag, input logic [15:0] base);
        logic [7:0] d;
        check({tag, "_nwr"}, 32'(log_addr.size()), 32'd8);
        if (log_addr.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                d = 8'(8'h11 * (k + 1));
                check($sformatf("%s_addr%0d", tag, k), 32'(log_addr[k]), 32'(base + 16'(k / 4)));
                check($sformatf("%s_be%0d", tag, k), 32'(log_be[k]), 32'(4'b0001 << (k % 4)));
                check($sformatf("%s_wd%0d", tag, k), log_data[k], {4{d}});
            end
        end
    endtask

    byte_q_t good_frame;
    byte_q_t f;

    initial begin
        good_frame = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33,
                       8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h9C};
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", {mem_address, mem_byteenable, mem_write, mem_chipselect,
                           cpu_reset_req, done, error, err_code, 5'd0}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready_after", 32'(s_ready), 32'd1);

        // Idle noise is dropped
        send_byte(8'h3C);
        s_valid = 1'b0;
        check("idle_noise_busy", 32'(busy), 32'd0);

        // Good frame with valid held high, probing timing along the way
        clear_log();
        for (int i = 0; i < good_frame.size(); i++) begin
            send_byte(good_frame[i]);
            if (i == 0) begin
                check("good_cpurst_rise", 32'(cpu_reset_req), 32'd1);
                check("good_busy", 32'(busy), 32'd1);
            end
            if (i == 5) begin
                check("good_wr_first", {mem_write, mem_chipselect}, 32'd3);
                check("good_wr_addr", 32'(mem_address), 32'h10);
            end
        end
        s_valid = 1'b0;
        check("good_fin_ready", 32'(s_ready), 32'd0);
        check("good_fin_done", 32'(done), 32'd1);
        check("good_fin_cpurst", 32'(cpu_reset_req), 32'd1);
        @(posedge clk);
        #1;
        check("good_cpurst_fall", 32'(cpu_reset_req), 32'd0);
        check("good_status", {s_ready, busy, done, error, err_code}, 32'b101000);
        check_writes("good", 16'h0010);

        // Range error: start 49999, N=2
        clear_log();
        f = '{8'hA5, 8'hC3, 8'h4F, 8'h00, 8'h02};
        send_frame(f, 0);
        check("range_fin", 32'(s_ready), 32'd0);
        check("range_status", {done, error, err_code}, 32'b0101);
        repeat (3) @(posedge clk);
        #1;
        check("range_nwr", 32'(log_addr.size()), 32'd0);
        check("range_idle", {busy, cpu_reset_req}, 32'd0);

        // Bad checksum: writes still happen
        clear_log();
        f = good_frame;
        f[13] = 8'h9D;
        send_frame(f, 0);
        repeat (2) @(posedge clk);
        #1;
        check("badcs_status", {done, error, err_code}, 32'b0110);
        check_writes("badcs", 16'h0010);

        // N = 0, good and bad checksum
        clear_log();
        f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(f, 0);
        repeat (2) @(posedge clk);
        #1;
        check("n0_status", {done, error, err_code}, 32'b1000);
        check("n0_nwr", 32'(log_addr.size()), 32'd0);
        f[5] = 8'h01;
        send_frame(f, 0);
        repeat (2) @(posedge clk);
        #1;
        check("n0_bad_status", {done, error, err_code}, 32'b0110);

        // Timeout after 3 data bytes
        clear_log();
        f = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        send_frame(f, 0);
        repeat (15) @(posedge clk);
        #1;
        check("tmo_before", {busy, error, err_code}, 32'b1000);
        @(posedge clk);
        #1;
        check("tmo_hit", {error, err_code, s_ready}, 32'b1110);
        check("tmo_fin_cpurst", 32'(cpu_reset_req), 32'd1);
        @(posedge clk);
        #1;
        check("tmo_cpurst_fall", {cpu_reset_req, busy}, 32'd0);
        check("tmo_nwr", 32'(log_addr.size()), 32'd3);
        send_frame(good_frame, 0);
        repeat (2) @(posedge clk);
        #1;
        check("tmo_recover", {done, error, err_code}, 32'b1000);

        // Random gaps, reset pulsed mid-DATA
        clear_log();
        f = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        send_frame(f, 3);
        check("rstmid_wr_live", 32'(mem_write), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rstmid_outs", {s_ready, busy, cpu_reset_req, mem_write, mem_chipselect,
                              done, error, err_code}, 32'd0);
        check("rstmid_addr", {mem_address, mem_byteenable}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("rstmid_nwr", 32'(log_addr.size()), 32'd2);
        @(posedge clk);
        #1;
        clear_log();
        send_frame(good_frame, 3);
        repeat (2) @(posedge clk);
        #1;
        check("rstmid_recover", {done, error, err_code, cpu_reset_req}, 32'b10000);
        check_writes("rstmid", 16'h0010);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/instruction_memory_loader.md
# instruction_memory_loader

Boot-time program loader that sits directly upstream of the 50000-word instruction memory and writes into its Avalon write port. It receives a framed byte stream (from the host/UART bridge) carrying a start word address, a word count and the program bytes. It writes each byte into memory with one-hot byteenables and checks a modulo-256 checksum. The CPU is held in reset from frame start until the frame completes.

## Interface
- `DEPTH`, 50000: memory depth in 32-bit words; the range-check limit.
- `TIMEOUT_CYCLES`, 1000000: maximum idle cycles between accepted bytes inside a frame; must be ≥2; counter width is clog2(TIMEOUT_CYCLES+1).
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input byte valid.
- `s_data`  in  8  input byte.
- `s_ready`  out  1  loader can accept a byte; transfer when `s_valid & s_ready`.
- `mem_address`  out  16  word address to the instruction memory.
- `mem_byteenable`  out  4  one-hot byte lane.
- `mem_chipselect`  out  1  write strobe qualifier.
- `mem_write`  out  1  write strobe.
- `mem_writedata`  out  32  byte replicated in all four lanes.
- `cpu_reset_req`  out  1  holds the processor in reset while loading.
- `busy`  out  1  frame in progress (any state except IDLE).
- `done`  out  1  sticky: last frame completed with good checksum.
- `error`  out  1  sticky: last frame failed.
- `err_code`  out  2  0 = none, 1 = range, 2 = checksum, 3 = timeout.

## Operation
- Frame format: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, N×4 data bytes, CSUM. All multi-byte fields are big-endian. N counts words.
- States: IDLE → ADDR_H → ADDR_L → CNT_H → CNT_L → DATA → CSUM → FIN.
  - IDLE: bytes other than SYNC are accepted and dropped. On SYNC: clear `done`, `error` and `err_code`; set `cpu_reset_req`; go to ADDR_H.
  - CNT_L accept: check `start + N > DEPTH` using 17-bit arithmetic. On failure go to FIN with err_code 1 and issue no writes. If N = 0, go to CSUM. Otherwise go to DATA.
  - DATA: data byte k (0-based) targets word `start + k/4`, lane `k%4` (lane 0 = byteenable 4'b0001). Each byte is added into an 8-bit running sum. After byte 4N−1, go to CSUM.
  - CSUM: accepted byte c is good if `(sum + c) mod 256 == 0`, giving `done`=1. Otherwise `error`=1, err_code 2. Bytes already written are not rolled back. Go to FIN.
  - Timeout: in any state from ADDR_H through CSUM, a counter reloads on every accepted byte. Reaching TIMEOUT_CYCLES with no transfer sets err_code 3 and goes to FIN.
  - FIN: lasts one cycle. `s_ready`=0, `cpu_reset_req` drops, then return to IDLE.
- `s_ready` = 1 in all states except FIN and reset.
- Only the most recent frame's result is held. A new SYNC in IDLE clears the status.
- A SYNC value appearing mid-frame is treated as ordinary data, with no resync.

## Timing
- Reset values: `s_ready`=0 while `reset_n` is low, then 1 from the first clock after release. All other outputs are 0, and state is IDLE.
- Reset asserted mid-frame: all outputs return to 0 immediately (asynchronous). Any in-flight write pulse is cancelled.
- Write latency: for a data byte accepted at edge t, `mem_chipselect` and `mem_write` are high for exactly one cycle (t to t+1). Address, byteenable and writedata are registered and valid in that same cycle.
  - Outside write cycles, `mem_address`, `mem_byteenable` and `mem_writedata` hold their last values, and strobes are 0.
- Back-to-back bytes produce back-to-back single-cycle writes. There is no memory backpressure.
- `cpu_reset_req` rises the cycle after SYNC is accepted. It falls the cycle after FIN, i.e. one cycle after the final write pulse or the error decision.
- `done`/`error` are set in the FIN cycle and hold until the next SYNC acceptance or reset.
- Timeout is exact: err_code 3 is set on the TIMEOUT_CYCLES-th consecutive cycle without a transfer.

## Test plan
- Good frame A5 00 10 00 02 11 22 33 44 55 66 77 88 9C, sent with valid held high. Required: 8 writes.
  - Addresses 0x0010 ×4 with be 1,2,4,8, then 0x0011 ×4.
  - Writedata 0x11111111 … 0x88888888.
  - Then `done`=1, err_code 0, `cpu_reset_req` low.
- Range: A5 C3 4F 00 02 (start 49999, N = 2) → no write strobes, `error`=1, err_code 1, FIN entered right after CNT_L.
- Bad checksum: same as the good frame but CSUM 9D → all 8 writes occur, `error`=1, err_code 2.
- N = 0: A5 00 00 00 00 00 → no writes, `done`=1. A CSUM of 01 instead gives err_code 2.
- Timeout with TIMEOUT_CYCLES = 16: stop after 3 data bytes → err_code 3 exactly 16 cycles after the last transfer, and `cpu_reset_req` falls. A following good frame then clears `error` and sets `done`.
- Random `s_valid` gaps plus `reset_n` pulsed mid-DATA → outputs reach 0 asynchronously, no further writes occur, and a subsequent good frame loads correctly.
